// File: rtl/ascii_uart_tx_if.sv
// Character handshake between the ASCII generator (master) and the UART transmitter (slave).
interface ascii_uart_tx_if;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_in,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_in,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: single-entry buffered 8N1 UART transmitter, LSB first.
// Optional macro UART_PARITY_EN inserts an even-parity bit before the stop bit.
//
// state  | meaning
// IDLE   | line high, waiting for a buffered character
// START  | start bit (low)
// DATA   | eight data bits, shift[0] on the line
// PARITY | even-parity bit (only with UART_PARITY_EN)
// STOP   | stop bit (high); reloads from the buffer for gap-free frames
module ascii_uart_tx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic             clk,
    input  logic             rst_n,
    ascii_uart_tx_if.slave   char_if,
    output logic             tx_o,
    output logic             busy_o,
    output logic             tx_done_o
);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  buf_q, buf_d;
    logic        buf_full_q, buf_full_d;
    logic        ready_q, ready_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bit_end;
    logic        load;
    logic        accept;
`ifdef UART_PARITY_EN
    logic        parity_q, parity_d;
`endif

    assign char_if.char_ready = ready_q;
    assign tx_o               = tx_q;
    assign busy_o             = busy_q;
    assign tx_done_o          = done_q;

    // State, datapath and registered outputs; reset drops the line high and empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ready_q    <= 1'b1;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ready_q    <= ready_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // Next state, buffer handling and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 16'd1;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        load       = 1'b0;
        bit_end    = (timer_q == BIT_LAST);
        accept     = char_if.char_valid && ready_q;
`ifdef UART_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                load    = buf_full_q;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    timer_d   = '0;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    timer_d = '0;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (buf_full_q) load = 1'b1;
                    else            state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        // Load needs a full buffer and accept an empty one, so they never collide.
        if (load) begin
            state_d    = ST_START;
            timer_d    = '0;
            shift_d    = buf_q;
            buf_full_d = 1'b0;
`ifdef UART_PARITY_EN
            parity_d   = ^buf_q;
`endif
        end
        if (accept) begin
            buf_d      = char_if.char_in;
            buf_full_d = 1'b1;
        end

        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_STOP) && (timer_d == BIT_LAST);
        ready_d = ~buf_full_d;
    end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Bench for ascii_uart_tx: a frame-level reference model predicts tx/busy/tx_done/char_ready
// every cycle from the accepted character stream.
module tb_ascii_uart_tx;
    localparam int CPB = 4;
`ifdef UART_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic tx, busy, tx_done;
    ascii_uart_tx_if bus();

    ascii_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .char_if   (bus),
        .tx_o      (tx),
        .busy_o    (busy),
        .tx_done_o (tx_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: per-cycle expected {tx, busy, tx_done} for frames already started,
    // plus the single-entry buffer contents.
    logic [2:0] exp_q[$];
    logic [7:0] m_buf;
    logic       m_full;
    int         acc_cyc[$];
    logic [7:0] acc_chr[$];
    int         done_seen;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] c);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(c[i]);
`ifdef UART_PARITY_EN
        bits.push_back(^c);
`endif
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++)
            for (int j = 0; j < CPB; j++)
                exp_q.push_back({bits[b], 1'b1, (b == bits.size() - 1 && j == CPB - 1)});
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_full = 1'b0;
    endtask

    // Called at a negedge with inputs already driven: advance the model across the next
    // rising edge, then sample the DUT on the following falling edge.
    task automatic tick();
        logic load, acc;
        logic [2:0] e;
        load = rst_n && m_full && (exp_q.size() == 0);
        acc  = rst_n && bus.char_valid && !m_full;
        if (load) begin
            push_frame(m_buf);
            m_full = 1'b0;
        end
        if (acc) begin
            m_buf  = bus.char_in;
            m_full = 1'b1;
            acc_cyc.push_back(cyc);
            acc_chr.push_back(bus.char_in);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b100;
        if (tx_done === 1'b1) done_seen++;
        chk("tx", {7'd0, tx}, {7'd0, e[2]});
        chk("busy", {7'd0, busy}, {7'd0, e[1]});
        chk("tx_done", {7'd0, tx_done}, {7'd0, e[0]});
        chk("char_ready", {7'd0, bus.char_ready}, {7'd0, ~m_full});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || m_full) && n < budget) begin
            tick();
            n++;
        end
        chk("drain_timeout", {7'd0, (exp_q.size() > 0 || m_full)}, 8'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        chk("rst_tx", {7'd0, tx}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, tx_done}, 8'd0);
        chk("rst_ready", {7'd0, bus.char_ready}, 8'd1);
        model_clear();
        @(negedge clk);
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int d0, a0;
        rst_n = 1'b1;
        bus.char_valid = 1'b0;
        bus.char_in = 8'h00;
        model_clear();
        done_seen = 0;
        #2;

        // 1: reset with char_valid high (ignored), then quiet idle
        bus.char_valid = 1'b1;
        bus.char_in = 8'h55;
        do_reset(3);
        bus.char_valid = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("idle_no_accept", 8'(acc_cyc.size()), 8'd0);

        // 2: single 0x41 frame
        bus.char_valid = 1'b1;
        bus.char_in = 8'h41;
        d0 = done_seen;
        tick();
        bus.char_valid = 1'b0;
        bus.char_in = 8'hFF;
        drain(200);
        for (int i = 0; i < 5; i++) tick();
        chk("one_done_pulse", 8'(done_seen - d0), 8'd1);

        // 3+4: 0x41, then held 0x42, then held 0x43 while 0x42 is queued
        bus.char_valid = 1'b1;
        bus.char_in = 8'h41;
        a0 = acc_cyc.size();
        tick();
        bus.char_in = 8'h42;
        while (acc_cyc.size() < a0 + 2 && cyc < 5000) tick();
        chk("second_accept_gap", 8'(acc_cyc[a0 + 1] - acc_cyc[a0]), 8'd2);
        bus.char_in = 8'h43;
        while (acc_cyc.size() < a0 + 3 && cyc < 5000) tick();
        chk("third_accept_gap", 8'(acc_cyc[a0 + 2] - acc_cyc[a0 + 1]), 8'(FRAME_BITS * CPB));
        chk("third_char", acc_chr[a0 + 2], 8'h43);
        bus.char_valid = 1'b0;
        drain(500);

        // 5: reset at cycle 15 of a 0x41 frame with 0x42 queued
        bus.char_valid = 1'b1;
        bus.char_in = 8'h41;
        tick();
        bus.char_in = 8'h42;
        for (int i = 0; i < 15; i++) tick();
        bus.char_valid = 1'b0;
        chk("queued_before_rst", {7'd0, m_full}, 8'd1);
        d0 = done_seen;
        do_reset(3);
        for (int i = 0; i < 60; i++) tick();
        chk("no_done_after_rst", 8'(done_seen - d0), 8'd0);

        // 6: parity pair 0x43 / 0x41 (8N1 in default build)
        bus.char_valid = 1'b1;
        bus.char_in = 8'h43;
        tick();
        bus.char_in = 8'h41;
        while (m_full && cyc < 20000) tick();
        tick();
        bus.char_valid = 1'b0;
        drain(500);

        // Random characters with random valid gaps
        for (int i = 0; i < 600; i++) begin
            bus.char_valid = ($urandom_range(0, 3) != 0);
            bus.char_in = 8'($urandom);
            tick();
        end
        bus.char_valid = 1'b0;
        drain(500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
